alu_issue: RTL and testbench
============================

# alu_issue

Issue and writeback stage directly upstream of the 8-bit ALU. Accepts opcode bytes from fetch, decodes register-to-register ALU, immediate-ALU, misc (DAA/CPL/SCF/CCF) and CB-prefixed instructions, reads operands from the register file, and pulses `alu_begin` with the decoded fields. It then captures `res`/`flags_res`, writes the destination register, and holds the architectural F register.

## Interface
- No parameters.
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `byte_valid` in 1, `byte_data` in 8, `byte_ready` out 1: fetch handshake. A transfer occurs when valid & ready are both high at a `clk` edge.
- `rf_addr_a` out 3, `rf_data_a` in 8: source read port (combinational RF).
- `rf_addr_b` out 3, `rf_data_b` in 8: destination read port.
- `rf_wr_en` out 1, `rf_wr_addr` out 3, `rf_wr_data` out 8: register writeback.
- `t_cycle` out 2, `alu_begin` out 1, `op` out 3, `src_addr` out 3, `dest_addr` out 3, `src_data` out 8, `dest_data` out 8, `flags_in` out 8, `ext` out 1, `misc` out 1: to ALU.
- `res` in 8, `flags_res` in 8, `wr_en_flags` in 1: from ALU.
- `flags_q` out 8: architectural F. Bits [3:0] are always 0.
- `instr_done` out 1: one-cycle pulse on completion.
- `unsupported` out 1: one-cycle pulse when an accepted opcode is dropped.

## Operation
- States: IDLE, CB_WAIT, IMM_WAIT, EXEC, WB.
- `byte_ready` = 1 in IDLE, CB_WAIT and IMM_WAIT; 0 in EXEC and WB.
- Decode in IDLE:
  - 0x80–0xBF: op = [5:3], src = [2:0], dest = 7.
  - 0xC6/CE/D6/DE/E6/EE/F6/FE (imm ALU): op = [5:3]; go to IMM_WAIT. The next byte becomes `src_data`.
  - 0x27/2F/37/3F: misc = 1, op = {0, [4:3]}, src = dest = 7.
  - 0xCB: go to CB_WAIT.
- Decode in CB_WAIT:
  - [7:6] = 00: ext = 1, misc = 0, op = [5:3], src = dest = [2:0].
  - Otherwise: ext = 1, misc = 1, op = {0, [7:6]}, src = [5:3] (bit number), dest = [2:0].
- Register index 6 ((HL)) in any src/dest register field, and every other opcode, is rejected: `unsupported` pulses, the block returns to or stays in IDLE, and there is no ALU activity.
- On entry to EXEC, `src_data`/`dest_data` latch from `rf_data_a`/`rf_data_b`. The immediate byte replaces `src_data`. For BIT/RES/SET, `src_data` is the RF value at dest.
- `flags_in` = `flags_q`, latched on entry to EXEC.
- WB: when `wr_en_flags` = 1:
  - `flags_q` <= {`flags_res`[7:4], 4'b0}.
  - `rf_wr_en` = 1 to `dest_addr` with `res`, except for CP, BIT, SCF and CCF, which update flags only.
  - `instr_done` pulses and the FSM goes to IDLE.
- WB holds (no timeout) while `wr_en_flags` = 0.
- Reset values: state IDLE, `flags_q` 0x00, all data/field outputs 0, `alu_begin`/`rf_wr_en`/`instr_done`/`unsupported` 0, `t_cycle` 0, `byte_ready` 1.
- `rst` in any state: IDLE on the next edge, no writeback, and a pending CB/immediate byte is discarded.

## Timing
- The opcode is accepted at edge N. EXEC occupies cycle N+1 with `alu_begin` = 1 and `t_cycle` = 1. WB occupies cycle N+2 with `t_cycle` = 2. The write commits at the end of N+2, and the next opcode can be accepted at the end of N+3 at the earliest.
- CB and immediate forms add one byte-acceptance cycle. Fetch stalls extend the wait states indefinitely.
- `alu_begin` is a registered, one-cycle pulse with fields stable from EXEC through WB. The ALU computes on its rising edge.
- `t_cycle` returns to 0 in IDLE, which clears the ALU's `wr_en_flags`.
- `rf_wr_*`, `instr_done` and `unsupported` are combinational from state/inputs and are valid within the cycle.

## Structure
- Package `gb_alu_pkg` holds:
  - ALU/ext/misc/bit-op opcode localparams.
  - Flag bit indices (Z = 7, N = 6, H = 5, C = 4).
  - The state enum.
  - Register index constants (A = 7, HL_IND = 6).
- Sub-module `alu_decode` (combinational): byte and CB flag in; op, src, dest, ext, misc, needs_imm, is_cb_prefix, writes_reg and legal out.

## Test plan
- Reset: `rst` high for 2 cycles -> `byte_ready` = 1, `alu_begin` = 0, `t_cycle` = 0, `flags_q` = 0x00, `rf_wr_en` = 0.
- 0x80 with A = 0x3C, B = 0x12, ALU model returning res 0x4E and flags 0x00 -> EXEC shows op 000, src 0, dest 7, src_data 0x12, dest_data 0x3C. WB writes reg 7 = 0x4E, `instr_done` pulses.
- 0xCB, 0x7C (BIT 7,H) -> ext = 1, misc = 1, op 001, src_addr 7, dest_addr 4. No RF write; `flags_q` = `flags_res` & 0xF0.
- 0xE6, 0x0F with A = 0xF3, fetch stalls 3 cycles between the bytes -> src_data 0x0F, `byte_ready` low in EXEC/WB, A <= 0x03.
- 0x86 then 0xD3 -> two `unsupported` pulses, no `alu_begin`, `byte_ready` stays 1.
- `rst` asserted during WB with `wr_en_flags` = 1 -> no RF write, IDLE the next cycle, `flags_q` = 0x00.

Source files
------------

// File: rtl/gb_alu_pkg.sv
// rtl/gb_alu_pkg.sv - shared opcodes, flag indices, register indices and FSM states for the ALU issue stage
package gb_alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_ADC = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_SBC = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_CP  = 3'd7;

    localparam logic [2:0] EXT_RLC  = 3'd0;
    localparam logic [2:0] EXT_RRC  = 3'd1;
    localparam logic [2:0] EXT_RL   = 3'd2;
    localparam logic [2:0] EXT_RR   = 3'd3;
    localparam logic [2:0] EXT_SLA  = 3'd4;
    localparam logic [2:0] EXT_SRA  = 3'd5;
    localparam logic [2:0] EXT_SWAP = 3'd6;
    localparam logic [2:0] EXT_SRL  = 3'd7;

    localparam logic [2:0] MISC_DAA = 3'd0;
    localparam logic [2:0] MISC_CPL = 3'd1;
    localparam logic [2:0] MISC_SCF = 3'd2;
    localparam logic [2:0] MISC_CCF = 3'd3;

    localparam logic [2:0] BIT_BIT = 3'd1;
    localparam logic [2:0] BIT_RES = 3'd2;
    localparam logic [2:0] BIT_SET = 3'd3;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    localparam logic [2:0] REG_A      = 3'd7;
    localparam logic [2:0] REG_HL_IND = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CB_WAIT  = 3'd1,
        ST_IMM_WAIT = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WB       = 3'd4
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational decode of a primary or CB-prefixed opcode byte into ALU fields
module alu_decode
    import gb_alu_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic       i_cb,
    output logic [2:0] o_op,
    output logic [2:0] o_src,
    output logic [2:0] o_dest,
    output logic       o_ext,
    output logic       o_misc,
    output logic       o_needs_imm,
    output logic       o_is_cb_prefix,
    output logic       o_writes_reg,
    output logic       o_legal
);

    always_comb begin
        o_op           = 3'd0;
        o_src          = 3'd0;
        o_dest         = 3'd0;
        o_ext          = 1'b0;
        o_misc         = 1'b0;
        o_needs_imm    = 1'b0;
        o_is_cb_prefix = 1'b0;
        o_writes_reg   = 1'b0;
        o_legal        = 1'b0;
        if (i_cb) begin
            o_ext   = 1'b1;
            o_dest  = i_byte[2:0];
            o_legal = (i_byte[2:0] != REG_HL_IND);
            if (i_byte[7:6] == 2'b00) begin
                o_op         = i_byte[5:3];
                o_src        = i_byte[2:0];
                o_writes_reg = 1'b1;
            end else begin
                // BIT/RES/SET: src carries the bit number, not a register
                o_misc       = 1'b1;
                o_op         = {1'b0, i_byte[7:6]};
                o_src        = i_byte[5:3];
                o_writes_reg = ({1'b0, i_byte[7:6]} != BIT_BIT);
            end
        end else if (i_byte[7:6] == 2'b10) begin
            o_op         = i_byte[5:3];
            o_src        = i_byte[2:0];
            o_dest       = REG_A;
            o_legal      = (i_byte[2:0] != REG_HL_IND);
            o_writes_reg = (i_byte[5:3] != ALU_CP);
        end else if (i_byte[7:6] == 2'b11 && i_byte[2:0] == 3'b110) begin
            o_op         = i_byte[5:3];
            o_dest       = REG_A;
            o_needs_imm  = 1'b1;
            o_legal      = 1'b1;
            o_writes_reg = (i_byte[5:3] != ALU_CP);
        end else if (i_byte[7:5] == 3'b001 && i_byte[2:0] == 3'b111) begin
            o_misc       = 1'b1;
            o_op         = {1'b0, i_byte[4:3]};
            o_src        = REG_A;
            o_dest       = REG_A;
            o_legal      = 1'b1;
            o_writes_reg = ({1'b0, i_byte[4:3]} == MISC_DAA) || ({1'b0, i_byte[4:3]} == MISC_CPL);
        end else if (i_byte == 8'hCB) begin
            o_is_cb_prefix = 1'b1;
            o_legal        = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue/writeback stage: fetch handshake, operand read, ALU launch, RF writeback and F register
module alu_issue
    import gb_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic [2:0] rf_addr_a,
    input  logic [7:0] rf_data_a,
    output logic [2:0] rf_addr_b,
    input  logic [7:0] rf_data_b,
    output logic       rf_wr_en,
    output logic [2:0] rf_wr_addr,
    output logic [7:0] rf_wr_data,
    output logic [1:0] t_cycle,
    output logic       alu_begin,
    output logic [2:0] op,
    output logic [2:0] src_addr,
    output logic [2:0] dest_addr,
    output logic [7:0] src_data,
    output logic [7:0] dest_data,
    output logic [7:0] flags_in,
    output logic       ext,
    output logic       misc,
    input  logic [7:0] res,
    input  logic [7:0] flags_res,
    input  logic       wr_en_flags,
    output logic [7:0] flags_q,
    output logic       instr_done,
    output logic       unsupported
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_imm_op;
    logic [2:0] r_op;
    logic [2:0] r_src;
    logic [2:0] r_dest;
    logic [7:0] r_src_data;
    logic [7:0] r_dest_data;
    logic [7:0] r_flags_in;
    logic [7:0] r_flags_q;
    logic       r_ext;
    logic       r_misc;
    logic       r_writes;
    logic       r_alu_begin;

    logic [2:0] w_op;
    logic [2:0] w_src;
    logic [2:0] w_dest;
    logic       w_ext;
    logic       w_misc;
    logic       w_needs_imm;
    logic       w_is_cb;
    logic       w_writes;
    logic       w_legal;

    logic       w_ready;
    logic [1:0] w_tcycle;
    logic       w_unsup;
    logic       w_load_dec;
    logic       w_load_imm;
    logic       w_save_imm;
    logic       w_done;
    logic       w_unused;

    alu_decode u_decode (
        .i_byte         (byte_data),
        .i_cb           (r_state == ST_CB_WAIT),
        .o_op           (w_op),
        .o_src          (w_src),
        .o_dest         (w_dest),
        .o_ext          (w_ext),
        .o_misc         (w_misc),
        .o_needs_imm    (w_needs_imm),
        .o_is_cb_prefix (w_is_cb),
        .o_writes_reg   (w_writes),
        .o_legal        (w_legal)
    );

    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        w_tcycle   = 2'd0;
        w_unsup    = 1'b0;
        w_load_dec = 1'b0;
        w_load_imm = 1'b0;
        w_save_imm = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (byte_valid) begin
                    if (!w_legal) begin
                        w_unsup = 1'b1;
                    end else if (w_is_cb) begin
                        w_next = ST_CB_WAIT;
                    end else if (w_needs_imm) begin
                        w_next     = ST_IMM_WAIT;
                        w_save_imm = 1'b1;
                    end else begin
                        w_next     = ST_EXEC;
                        w_load_dec = 1'b1;
                    end
                end
            end
            ST_CB_WAIT: begin
                w_ready = 1'b1;
                if (byte_valid) begin
                    if (!w_legal) begin
                        w_unsup = 1'b1;
                        w_next  = ST_IDLE;
                    end else begin
                        w_next     = ST_EXEC;
                        w_load_dec = 1'b1;
                    end
                end
            end
            ST_IMM_WAIT: begin
                w_ready = 1'b1;
                if (byte_valid) begin
                    w_next     = ST_EXEC;
                    w_load_imm = 1'b1;
                end
            end
            ST_EXEC: begin
                w_tcycle = 2'd1;
                w_next   = ST_WB;
            end
            ST_WB: begin
                w_tcycle = 2'd2;
                if (wr_en_flags) begin
                    w_done = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_imm_op    <= 3'd0;
            r_op        <= 3'd0;
            r_src       <= 3'd0;
            r_dest      <= 3'd0;
            r_src_data  <= 8'h00;
            r_dest_data <= 8'h00;
            r_flags_in  <= 8'h00;
            r_flags_q   <= 8'h00;
            r_ext       <= 1'b0;
            r_misc      <= 1'b0;
            r_writes    <= 1'b0;
            r_alu_begin <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_alu_begin <= w_load_dec | w_load_imm;
            if (w_save_imm) begin
                r_imm_op <= w_op;
            end
            if (w_load_dec) begin
                r_op        <= w_op;
                r_src       <= w_src;
                r_dest      <= w_dest;
                r_ext       <= w_ext;
                r_misc      <= w_misc;
                r_writes    <= w_writes;
                r_src_data  <= rf_data_a;
                r_dest_data <= rf_data_b;
                r_flags_in  <= r_flags_q;
            end
            if (w_load_imm) begin
                r_op        <= r_imm_op;
                r_src       <= 3'd0;
                r_dest      <= REG_A;
                r_ext       <= 1'b0;
                r_misc      <= 1'b0;
                r_writes    <= (r_imm_op != ALU_CP);
                r_src_data  <= byte_data;
                r_dest_data <= rf_data_b;
                r_flags_in  <= r_flags_q;
            end
            if (w_done) begin
                r_flags_q <= {flags_res[FLAG_Z], flags_res[FLAG_N], flags_res[FLAG_H], flags_res[FLAG_C], 4'b0000};
            end
        end
    end

    // BIT/RES/SET operate on the dest register, so port A follows dest for them
    assign rf_addr_a = (r_state == ST_IMM_WAIT) ? REG_A : ((w_ext && w_misc) ? w_dest : w_src);
    assign rf_addr_b = (r_state == ST_IMM_WAIT) ? REG_A : w_dest;

    assign byte_ready  = w_ready;
    assign t_cycle     = w_tcycle;
    assign rf_wr_en    = w_done && r_writes && !rst;
    assign rf_wr_addr  = rf_wr_en ? r_dest : 3'd0;
    assign rf_wr_data  = rf_wr_en ? res : 8'h00;
    assign instr_done  = w_done && !rst;
    assign unsupported = w_unsup && !rst;

    assign alu_begin = r_alu_begin;
    assign op        = r_op;
    assign src_addr  = r_src;
    assign dest_addr = r_dest;
    assign src_data  = r_src_data;
    assign dest_data = r_dest_data;
    assign flags_in  = r_flags_in;
    assign ext       = r_ext;
    assign misc      = r_misc;
    assign flags_q   = r_flags_q;

    assign w_unused = ^flags_res[3:0];

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed bench for alu_issue with an instruction-level reference model
module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic [2:0] rf_addr_a, rf_addr_b, rf_wr_addr;
    logic [7:0] rf_data_a, rf_data_b, rf_wr_data;
    logic       rf_wr_en;
    logic [1:0] t_cycle;
    logic       alu_begin, ext, misc, wr_en_flags, instr_done, unsupported;
    logic [2:0] op, src_addr, dest_addr;
    logic [7:0] src_data, dest_data, flags_in, res, flags_res, flags_q;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .rf_addr_a(rf_addr_a), .rf_data_a(rf_data_a),
        .rf_addr_b(rf_addr_b), .rf_data_b(rf_data_b),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .t_cycle(t_cycle), .alu_begin(alu_begin), .op(op),
        .src_addr(src_addr), .dest_addr(dest_addr),
        .src_data(src_data), .dest_data(dest_data), .flags_in(flags_in),
        .ext(ext), .misc(misc),
        .res(res), .flags_res(flags_res), .wr_en_flags(wr_en_flags),
        .flags_q(flags_q), .instr_done(instr_done), .unsupported(unsupported)
    );

    // register file and ALU surroundings
    logic [7:0] rf [8];
    logic       poke_en;
    logic [2:0] poke_addr;
    logic [7:0] poke_data;
    logic       alu_en;
    logic [7:0] alu_res, alu_flags;

    assign rf_data_a   = rf[rf_addr_a];
    assign rf_data_b   = rf[rf_addr_b];
    assign res         = alu_res;
    assign flags_res   = alu_flags;
    assign wr_en_flags = alu_en && (t_cycle == 2'd2);

    always @(posedge clk) begin
        if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
        else if (poke_en) rf[poke_addr] <= poke_data;
    end

    typedef struct packed {
        logic [2:0] op, src, dest;
        logic       ext, misc, wr;
        logic [7:0] sdata, ddata, fin, wdata, fexp;
    } exp_t;

    logic [7:0] m_rf [8];
    logic [7:0] m_flags;
    exp_t       expq[$];
    int         exp_unsup = 0, got_unsup = 0;
    int         total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic bit is_imm(input logic [7:0] b);
        return b inside {8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE};
    endfunction

    // What the stage must hand to the ALU for an instruction, from the architectural register file
    function automatic void model(input logic [7:0] b0, input logic [7:0] b1, output exp_t e, output bit lg);
        logic [7:0] t;
        e  = '0;
        lg = 1'b1;
        if (b0 >= 8'h80 && b0 <= 8'hBF) begin
            e.op = b0[5:3]; e.src = b0[2:0]; e.dest = 3'd7;
            e.sdata = m_rf[b0[2:0]]; e.wr = (b0[5:3] != 3'd7); lg = (b0[2:0] != 3'd6);
        end else if (is_imm(b0)) begin
            e.op = b0[5:3]; e.dest = 3'd7; e.sdata = b1; e.wr = (b0 != 8'hFE);
        end else if (b0 inside {8'h27, 8'h2F, 8'h37, 8'h3F}) begin
            t = (b0 - 8'h27) >> 3;
            e.misc = 1'b1; e.op = t[2:0]; e.src = 3'd7; e.dest = 3'd7;
            e.sdata = m_rf[7]; e.wr = (b0 == 8'h27 || b0 == 8'h2F);
        end else if (b0 == 8'hCB) begin
            e.ext = 1'b1; e.dest = b1[2:0]; e.sdata = m_rf[b1[2:0]]; lg = (b1[2:0] != 3'd6);
            if (b1 < 8'h40) begin
                e.op = b1[5:3]; e.src = b1[2:0]; e.wr = 1'b1;
            end else begin
                t = b1 >> 6;
                e.misc = 1'b1; e.op = t[2:0]; e.src = b1[5:3]; e.wr = (b1 >= 8'h80);
            end
        end else begin
            lg = 1'b0;
        end
        e.ddata = m_rf[e.dest];
        e.fin   = m_flags;
    endfunction

    // compare process: EXEC/WB contents against the model's expectation for each launched instruction
    exp_t cur;
    bit   in_wb = 1'b0, flag_pend = 1'b0;

    task automatic check_fields(input string tag, input exp_t e);
        chk({tag, "_op"}, op, e.op);
        chk({tag, "_src_addr"}, src_addr, e.src);
        chk({tag, "_dest_addr"}, dest_addr, e.dest);
        chk({tag, "_ext"}, ext, e.ext);
        chk({tag, "_misc"}, misc, e.misc);
        chk({tag, "_src_data"}, src_data, e.sdata);
        chk({tag, "_dest_data"}, dest_data, e.ddata);
        chk({tag, "_flags_in"}, flags_in, e.fin);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_wb     = 1'b0;
            flag_pend = 1'b0;
        end else begin
            if (flag_pend) begin
                chk("flags_q_after_wb", flags_q, cur.fexp);
                flag_pend = 1'b0;
            end
            if (in_wb) begin
                chk("wb_t_cycle", t_cycle, 2);
                chk("wb_byte_ready", byte_ready, 0);
                chk("wb_alu_begin", alu_begin, 0);
                check_fields("wb", cur);
                chk("wb_rf_wr_en", rf_wr_en, alu_en && cur.wr);
                if (alu_en && cur.wr) begin
                    chk("wb_rf_wr_addr", rf_wr_addr, cur.dest);
                    chk("wb_rf_wr_data", rf_wr_data, cur.wdata);
                end
                chk("wb_instr_done", instr_done, alu_en);
                if (alu_en) begin
                    in_wb     = 1'b0;
                    flag_pend = 1'b1;
                end
            end else if (alu_begin) begin
                chk("exec_expected", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    cur = expq.pop_front();
                    chk("exec_t_cycle", t_cycle, 1);
                    chk("exec_byte_ready", byte_ready, 0);
                    check_fields("exec", cur);
                    in_wb = 1'b1;
                end
            end else begin
                chk("idle_rf_wr_en", rf_wr_en, 0);
                chk("idle_instr_done", instr_done, 0);
            end
            if (unsupported) got_unsup++;
        end
    end

    task automatic poke(input logic [2:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d; m_rf[a] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        byte_valid = 1'b0;
        repeat (stall) begin
            @(negedge clk); chk("stall_byte_ready", byte_ready, 1);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1; byte_data = b;
        @(negedge clk);
        chk("byte_ready_at_send", byte_ready, 1);
        for (int i = 0; i < 8 && !byte_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        byte_valid = 1'b0; byte_data = 8'h00;
    endtask

    task automatic run(input logic [7:0] b0, input logic [7:0] b1, input int stall,
                       input logic [7:0] rv, input logic [7:0] fv, input int hold);
        exp_t e;
        bit   lg, seen;
        model(b0, b1, e, lg);
        e.wdata = rv;
        e.fexp  = {fv[7:4], 4'h0};
        alu_res = rv; alu_flags = fv; alu_en = (hold == 0);
        if (lg) expq.push_back(e);
        else exp_unsup++;
        send_byte(b0, 0);
        if (b0 == 8'hCB || is_imm(b0)) send_byte(b1, stall);
        if (lg) begin
            if (hold > 0) begin
                repeat (hold + 1) @(posedge clk);
                #1 alu_en = 1'b1;
            end
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk); seen = instr_done;
            end
            chk("instr_done_seen", seen, 1);
            @(posedge clk); #1;
            if (e.wr) m_rf[e.dest] = rv;
            m_flags = e.fexp;
        end else begin
            @(negedge clk);
            chk("unsup_byte_ready", byte_ready, 1);
            chk("unsup_no_alu_begin", alu_begin, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bit   lg;
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; poke_en = 1'b0;
        poke_addr = 3'd0; poke_data = 8'h00;
        alu_en = 1'b1; alu_res = 8'h00; alu_flags = 8'h00; m_flags = 8'h00;
        poke(3'd0, 8'h12); poke(3'd1, 8'h55); poke(3'd2, 8'h01); poke(3'd3, 8'h00);
        poke(3'd4, 8'h90); poke(3'd5, 8'h0F); poke(3'd6, 8'h00); poke(3'd7, 8'h3C);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_byte_ready", byte_ready, 1);
        chk("reset_alu_begin", alu_begin, 0);
        chk("reset_t_cycle", t_cycle, 0);
        chk("reset_flags_q", flags_q, 8'h00);
        chk("reset_rf_wr_en", rf_wr_en, 0);
        chk("reset_src_data", src_data, 8'h00);
        @(posedge clk); #1;

        // pin the model against hand-computed fields
        model(8'h80, 8'h00, e, lg);
        chk("pin80_legal", lg, 1); chk("pin80_op", e.op, 3'b000); chk("pin80_dest", e.dest, 3'd7);
        chk("pin80_sdata", e.sdata, 8'h12); chk("pin80_ddata", e.ddata, 8'h3C);
        model(8'hCB, 8'h7C, e, lg);
        chk("pinbit_op", e.op, 3'b001); chk("pinbit_src", e.src, 3'd7);
        chk("pinbit_dest", e.dest, 3'd4); chk("pinbit_wr", e.wr, 0);

        run(8'h80, 8'h00, 0, 8'h4E, 8'h00, 0);
        chk("add_b_a", rf[7], 8'h4E);
        chk("add_b_flags", flags_q, 8'h00);

        run(8'hCB, 8'h7C, 0, 8'h99, 8'hA5, 0);
        chk("bit7h_flags", flags_q, 8'hA0);
        chk("bit7h_h_kept", rf[4], 8'h90);
        chk("bit7h_a_kept", rf[7], 8'h4E);

        poke(3'd7, 8'hF3);
        run(8'hE6, 8'h0F, 3, 8'h03, 8'h20, 0);
        chk("and_imm_a", rf[7], 8'h03);
        chk("and_imm_flags", flags_q, 8'h20);

        run(8'h86, 8'h00, 0, 8'h00, 8'h00, 0);
        run(8'hD3, 8'h00, 0, 8'h00, 8'h00, 0);
        chk("two_unsup", got_unsup, 2);
        chk("unsup_flags_kept", flags_q, 8'h20);

        run(8'hCB, 8'h11, 0, 8'hAA, 8'h10, 3);
        chk("rl_c_hold", rf[1], 8'hAA);
        run(8'h37, 8'h00, 0, 8'h77, 8'h90, 0);
        chk("scf_a_kept", rf[7], 8'h03);
        chk("scf_flags", flags_q, 8'h90);
        run(8'h2F, 8'h00, 0, 8'h0C, 8'h60, 0);
        chk("cpl_a", rf[7], 8'h0C);
        run(8'hB8, 8'h00, 0, 8'h55, 8'hC0, 0);
        chk("cp_a_kept", rf[7], 8'h0C);
        chk("cp_flags", flags_q, 8'hC0);
        run(8'hCB, 8'hFB, 0, 8'h80, 8'hC0, 0);
        chk("set7e", rf[3], 8'h80);
        run(8'hCB, 8'h46, 0, 8'h00, 8'h00, 0);
        chk("cb_hl_unsup", got_unsup, 3);

        // reset landing in WB while the ALU is already offering its result
        model(8'h80, 8'h00, e, lg);
        e.wdata = 8'hFF; e.fexp = 8'hF0;
        expq.push_back(e);
        alu_res = 8'hFF; alu_flags = 8'hF0; alu_en = 1'b1;
        send_byte(8'h80, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wb_rf_wr_en", rf_wr_en, 0);
        chk("rst_wb_instr_done", instr_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wb_flags_q", flags_q, 8'h00);
        chk("rst_wb_byte_ready", byte_ready, 1);
        chk("rst_wb_t_cycle", t_cycle, 0);
        chk("rst_wb_a_kept", rf[7], 8'h0C);
        @(posedge clk); #1;
        m_flags = 8'h00;

        run(8'h80, 8'h00, 0, 8'h1E, 8'h00, 0);
        chk("after_rst_add", rf[7], 8'h1E);

        repeat (3) @(posedge clk);
        chk("queue_drained", expq.size(), 0);
        chk("unsup_count", got_unsup, exp_unsup);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
